muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the register file's registered ReadData1/ReadData2 as operands.
- Produces a single-cycle write request (WriteEn/WriteAddress/WriteData) that drives the register file write port.
- Stalls the core via Busy while an operation runs; one operation in flight at a time.

Parameters:
- XLEN, 32, operand and result width.
- ITER, 32, iteration cycles per MUL/DIV operation; equals XLEN.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- Start  input  1  launch request, sampled in IDLE only.
- Funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- OperandA  input  XLEN  rs1 value, from ReadData1.
- OperandB  input  XLEN  rs2 value, from ReadData2.
- DestAddr  input  5  rd index.
- Flush  input  1  abort the in-flight op; no writeback.
- Busy  output  1  high from the cycle after Start is accepted until Done.
- Done  output  1  one-cycle completion pulse.
- WriteEn  output  1  register file write strobe.
- WriteAddress  output  5  rd for the write.
- WriteData  output  XLEN  result.

Behaviour:
- Reset (async, RST_N=0):
  - State goes to IDLE.
  - Busy, Done, WriteEn, WriteAddress and WriteData are all 0.
  - Internal accumulators are cleared.
  - Reset mid-operation discards the op; no write is ever issued for it.
- States: IDLE, CALC, FINISH.
- IDLE, Start=1 at edge T0:
  - Capture Funct3, DestAddr, |A|, |B| and the sign flags.
  - Signed/unsigned interpretation per Funct3: MULHSU treats A signed, B unsigned; MULHU, DIVU and REMU are fully unsigned.
  - Next state is CALC with counter = ITER-1.
- Fast path at T0 (goes straight to FINISH):
  - Divide by zero, B==0 on ops 4-7: quotient = all ones, remainder = A.
  - Signed overflow, A=0x80000000 and B=0xFFFFFFFF on DIV/REM: quotient = 0x80000000, remainder = 0.
- CALC, one step per cycle:
  - MUL ops: shift-add into a 2*XLEN product.
  - DIV ops: restoring divide, one quotient bit per cycle.
  - Counter decrements; at 0, next state is FINISH.
- FINISH, one cycle, then IDLE:
  - Done=1.
  - Sign fixup: product is negated if the operand signs differ; quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - Result selection:
    - MUL: low XLEN bits of the product.
    - MULH, MULHSU, MULHU: high XLEN bits.
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - Registered outputs are valid in the same cycle as Done.
- Latency:
  - Normal op: Done at edge T0+ITER+1, i.e. 33 cycles.
  - Fast path: Done at T0+1.
- Busy is 1 in CALC and FINISH.
  - Start during Busy is ignored (no queueing).
  - Start in the FINISH cycle is ignored.
  - Start in the first IDLE cycle after FINISH is accepted.
- WriteEn = Done && DestAddr != 0.
  - For rd=0, Done still pulses, with WriteEn=0.
  - WriteAddress and WriteData hold their last value when WriteEn=0.
- Flush:
  - Flush=1 in CALC or FINISH returns the unit to IDLE next edge.
  - Done and WriteEn are forced to 0 in that cycle.
  - Flush has priority over completion.
  - Flush in IDLE has priority over Start; the op is not launched.
- Width: all arithmetic is modulo 2^XLEN except the internal 2*XLEN product and the XLEN+1-bit partial remainder.

Decomposition:
- Shared package rv32m_pkg holds:
  - Funct3 encodings (MUL..REMU).
  - State enum {IDLE, CALC, FINISH}.
  - XLEN constant.
  - DIV0_QUOTIENT constant (all ones).
  - INT_MIN constant.
- One natural sub-module: muldiv_datapath, holding the per-cycle shift-add/restoring step, abs/negate logic and result mux.
- The FSM, counter and handshake stay in muldiv_unit.

Test Plan:
- MUL 7 * 6, rd=5 -> WriteEn pulse after 33 cycles; WriteAddress=5, WriteData=42; Busy high for exactly 32 cycles plus the FINISH cycle.
- MULH 0xFFFFFFFF * 0xFFFFFFFF (-1*-1) -> 0x00000000; MULHU of the same operands -> 0xFFFFFFFE; MULHSU -1 * 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 / 2 -> 0xFFFFFFFF (-1); DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each with Done at T0+1; DIV 0x80000000 / -1 -> 0x80000000, REM -> 0.
- rd=0 MUL 3*3 -> Done pulses, WriteEn stays 0; Start asserted again during Busy -> ignored, only one Done.
- Flush at cycle 10 of a DIV -> no Done/WriteEn, Busy=0 next cycle; async RST_N low at cycle 20 of a MUL -> all outputs 0 immediately, no later write.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings, FSM states, widths.
package rv32m_pkg;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [XLEN-1:0] DIV0_QUOTIENT = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Bit 2 of funct3 separates the divide family from the multiply family.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Combinational datapath: operand abs/sign capture, special-case results, one shift-add or
// restoring-divide step per call, and sign fixup / result selection on the stepped values.
module muldiv_datapath
  import rv32m_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   operand_a,
  input  logic [XLEN-1:0]   operand_b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              neg_res,
  output logic              neg_rem,
  output logic              fast,
  output logic [XLEN-1:0]   fast_result,
  input  logic [2:0]        op,
  input  logic              op_neg_res,
  input  logic              op_neg_rem,
  input  logic [XLEN-1:0]   op_mag_b,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   rem,
  output logic [2*XLEN-1:0] prod_nxt,
  output logic [XLEN-1:0]   rem_nxt,
  output logic [XLEN-1:0]   result
);

  logic            signed_a;
  logic            signed_b;
  logic            neg_a;
  logic            neg_b;
  logic            div0;
  logic            ovf;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   part;
  logic [XLEN:0]   trial;
  logic            ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  // MUL is treated as signed*signed; its low half is identical either way.
  always_comb begin
    signed_a = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    signed_b = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    neg_a    = signed_a && operand_a[XLEN-1];
    neg_b    = signed_b && operand_b[XLEN-1];
    mag_a    = neg_a ? (~operand_a + 1'b1) : operand_a;
    mag_b    = neg_b ? (~operand_b + 1'b1) : operand_b;
    neg_res  = neg_a ^ neg_b;
    neg_rem  = neg_a;

    div0 = is_div_op(funct3) && (operand_b == '0);
    ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
           (operand_a == INT_MIN) && (operand_b == {XLEN{1'b1}});
    fast = div0 || ovf;

    fast_result = '0;
    if (div0)
      fast_result = funct3[1] ? operand_a : DIV0_QUOTIENT;
    else if (ovf)
      fast_result = funct3[1] ? '0 : INT_MIN;
  end

  // Multiply: low half of prod holds the shrinking multiplier, high half accumulates.
  // Divide: low half of prod holds the dividend shifting out MSB-first and the quotient shifting in.
  always_comb begin
    sum      = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, op_mag_b} : '0);
    part     = {rem, prod[XLEN-1]};
    trial    = part - {1'b0, op_mag_b};
    ge       = ~trial[XLEN];
    prod_nxt = '0;
    rem_nxt  = rem;
    if (is_div_op(op)) begin
      rem_nxt  = ge ? trial[XLEN-1:0] : part[XLEN-1:0];
      prod_nxt = {{XLEN{1'b0}}, prod[XLEN-2:0], ge};
    end else begin
      prod_nxt = {sum, prod[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = op_neg_res ? (~prod_nxt + 1'b1) : prod_nxt;
    quo_fix  = op_neg_res ? (~prod_nxt[XLEN-1:0] + 1'b1) : prod_nxt[XLEN-1:0];
    rem_fix  = op_neg_rem ? (~rem_nxt + 1'b1) : rem_nxt;
    case (op)
      F3_MUL:                     result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU,
      F3_MULHU:                   result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:            result = quo_fix;
      default:                    result = rem_fix;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: Done/write 33 cycles after Start (1 cycle for div-by-zero/overflow).
// One op in flight; Start is ignored while Busy, Flush aborts without writeback.
module muldiv_unit
  import rv32m_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] OperandA,
  input  logic [XLEN-1:0] OperandB,
  input  logic [4:0]      DestAddr,
  input  logic            Flush,
  output logic            Busy,
  output logic            Done,
  output logic            WriteEn,
  output logic [4:0]      WriteAddress,
  output logic [XLEN-1:0] WriteData
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op_q;
  logic [4:0]          rd_q;
  logic                neg_res_q;
  logic                neg_rem_q;
  logic [XLEN-1:0]     mag_b_q;
  logic [2*XLEN-1:0]   prod_q;
  logic [XLEN-1:0]     rem_q;
  logic                busy_q;
  logic                done_q;
  logic                wen_q;
  logic [4:0]          waddr_q;
  logic [XLEN-1:0]     wdata_q;

  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic                neg_res;
  logic                neg_rem;
  logic                fast;
  logic [XLEN-1:0]     fast_result;
  logic [2*XLEN-1:0]   prod_nxt;
  logic [XLEN-1:0]     rem_nxt;
  logic [XLEN-1:0]     result;

  muldiv_datapath u_datapath (
    .funct3      (Funct3),
    .operand_a   (OperandA),
    .operand_b   (OperandB),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .neg_res     (neg_res),
    .neg_rem     (neg_rem),
    .fast        (fast),
    .fast_result (fast_result),
    .op          (op_q),
    .op_neg_res  (neg_res_q),
    .op_neg_rem  (neg_rem_q),
    .op_mag_b    (mag_b_q),
    .prod        (prod_q),
    .rem         (rem_q),
    .prod_nxt    (prod_nxt),
    .rem_nxt     (rem_nxt),
    .result      (result)
  );

  // Completion registers are loaded on the edge entering FINISH so they are valid with Done.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mag_b_q   <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      done_q <= 1'b0;
      wen_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && !Flush) begin
            op_q      <= Funct3;
            rd_q      <= DestAddr;
            neg_res_q <= neg_res;
            neg_rem_q <= neg_rem;
            mag_b_q   <= mag_b;
            prod_q    <= {{XLEN{1'b0}}, mag_a};
            rem_q     <= '0;
            busy_q    <= 1'b1;
            if (fast) begin
              state  <= FINISH;
              done_q <= 1'b1;
              if (DestAddr != 5'd0) begin
                wen_q   <= 1'b1;
                waddr_q <= DestAddr;
                wdata_q <= fast_result;
              end
            end else begin
              state <= CALC;
              cnt   <= CNT_INIT;
            end
          end
        end
        CALC: begin
          if (Flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            prod_q <= prod_nxt;
            rem_q  <= rem_nxt;
            cnt    <= cnt - 1'b1;
            if (cnt == '0) begin
              state  <= FINISH;
              done_q <= 1'b1;
              if (rd_q != 5'd0) begin
                wen_q   <= 1'b1;
                waddr_q <= rd_q;
                wdata_q <= result;
              end
            end
          end
        end
        FINISH: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // A flush in the FINISH cycle still suppresses the pending completion.
  assign Busy         = busy_q;
  assign Done         = done_q && !Flush;
  assign WriteEn      = wen_q && !Flush;
  assign WriteAddress = waddr_q;
  assign WriteData    = wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: latency, results, rd=0, Start-while-busy, Flush, reset.
module tb_muldiv_unit;

  logic        CLK;
  logic        RST_N;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic [4:0]  DestAddr;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic        WriteEn;
  logic [4:0]  WriteAddress;
  logic [31:0] WriteData;

  int checks = 0;
  int errors = 0;
  logic [36:0] sb_q[$];

  muldiv_unit dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .Start        (Start),
    .Funct3       (Funct3),
    .OperandA     (OperandA),
    .OperandB     (OperandB),
    .DestAddr     (DestAddr),
    .Flush        (Flush),
    .Busy         (Busy),
    .Done         (Done),
    .WriteEn      (WriteEn),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one op at a negedge, then watch negedges until Done. dup_k re-asserts Start
  // for one cycle at that wait index to confirm it is ignored while Busy.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_data,
                        input int exp_lat, input int dup_k, input string tag);
    bit seen;
    int busy_cnt;
    logic [36:0] e;
    @(negedge CLK);
    Start = 1'b1; Funct3 = f3; OperandA = a; OperandB = b; DestAddr = rd;
    if (rd != 5'd0) sb_q.push_back({rd, exp_data});
    seen = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge CLK);
      Start = (k == dup_k);
      if (Busy) busy_cnt++;
      if (Done) begin
        seen = 1'b1;
        check({tag, "_latency"}, 64'(k), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        check({tag, "_wen"}, 64'(WriteEn), 64'(rd != 5'd0));
        if (WriteEn) begin
          check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_addr"}, 64'(WriteAddress), 64'(e[36:32]));
            check({tag, "_data"}, 64'(WriteData), 64'(e[31:0]));
          end
        end
      end
    end
    Start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge CLK);
    check({tag, "_busy_after"}, 64'(Busy), 64'd0);
    check({tag, "_done_after"}, 64'(Done), 64'd0);
  endtask

  task automatic count_done(input int cycles, output int n_done, output int n_wen);
    n_done = 0;
    n_wen  = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (Done) n_done++;
      if (WriteEn) n_wen++;
    end
  endtask

  initial begin
    int nd;
    int nw;
    RST_N = 1'b0; Start = 1'b0; Funct3 = '0; OperandA = '0; OperandB = '0;
    DestAddr = '0; Flush = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_wen", 64'(WriteEn), 64'd0);
    check("rst_waddr", 64'(WriteAddress), 64'd0);
    check("rst_wdata", 64'(WriteData), 64'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    run_op(3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 33, 0, "mul_7x6");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 33, 0, "mulh_m1m1");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33, 0, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 33, 0, "mulhsu_m1x2");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 33, 0, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 0, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33, 0, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 33, 0, "remu_100_7");
    run_op(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1, 0, "divu_by0");
    run_op(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1, 0, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1, 0, "rem_ovf");

    run_op(3'd0, 32'd3, 32'd3, 5'd0, 32'd9, 33, 5, "mul_rd0_dup");
    count_done(40, nd, nw);
    check("dup_extra_done", 64'(nd), 64'd0);

    // Flush during the tenth cycle of a divide.
    @(negedge CLK);
    Start = 1'b1; Funct3 = 3'd4; OperandA = 32'd1000; OperandB = 32'd3; DestAddr = 5'd13;
    @(negedge CLK);
    Start = 1'b0;
    repeat (8) @(negedge CLK);
    @(negedge CLK);
    Flush = 1'b1;
    check("flush_busy_during", 64'(Busy), 64'd1);
    check("flush_done", 64'(Done), 64'd0);
    check("flush_wen", 64'(WriteEn), 64'd0);
    @(negedge CLK);
    Flush = 1'b0;
    check("flush_busy_next", 64'(Busy), 64'd0);
    count_done(40, nd, nw);
    check("flush_no_done", 64'(nd), 64'd0);

    // Async reset in the middle of a multiply.
    @(negedge CLK);
    Start = 1'b1; Funct3 = 3'd0; OperandA = 32'd123; OperandB = 32'd456; DestAddr = 5'd14;
    @(negedge CLK);
    Start = 1'b0;
    repeat (18) @(negedge CLK);
    @(negedge CLK);
    check("midrst_busy_before", 64'(Busy), 64'd1);
    RST_N = 1'b0;
    #1;
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_done", 64'(Done), 64'd0);
    check("midrst_wen", 64'(WriteEn), 64'd0);
    check("midrst_waddr", 64'(WriteAddress), 64'd0);
    check("midrst_wdata", 64'(WriteData), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    count_done(40, nd, nw);
    check("midrst_no_write", 64'(nw), 64'd0);

    // The unit must still work after the aborted op.
    run_op(3'd0, 32'd123, 32'd456, 5'd15, 32'd56088, 33, 0, "mul_after_rst");
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
